// File: rtl/sha256_pkg.sv
// Purpose: shared constants, types and helpers for the SHA-256 round scheduler.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: K round constants, IV (word a at [31:0]), scheduler state enum, add_state8.
package sha256_pkg;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Initial hash value, word a (6a09e667) in the low 32 bits.
    localparam logic [255:0] IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_RESP
    } sched_state_e;

    // Eight independent 32-bit additions; carries never cross word boundaries.
    function automatic logic [255:0] add_state8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        end
        return s;
    endfunction

endpackage

// File: rtl/sha256_round_sched_rr_arbiter.sv
// Purpose: combinational round-robin arbiter; search starts one past the last winner.
// Latency: 0 cycles (pure combinational); pointer is owned by the caller.
// Backpressure: enable=0 forces an all-zero grant.
// Ports: valid[N] requests, last = previous winner index, enable, grant[N] one-hot.
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   valid,
    input  logic [IDW-1:0] last,
    input  logic           enable,
    output logic [N-1:0]   grant
);

    logic found;

    // Walk priority offsets 1..N from the pointer; the first valid position wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        if (enable) begin
            for (int off = 1; off <= N; off++) begin
                for (int j = 0; j < N; j++) begin
                    if (!found && valid[j] && (j == ((int'(last) + off) % N))) begin
                        grant[j] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sha256_round_sched.sv
// Purpose: shares one iterative SHA-256 round datapath among NUM_REQ requesters, sequences 64 rounds, adds chaining value.
// Latency: 65 cycles accept-to-rsp_valid; 67-cycle minimum job period with rsp_ready held high.
// Backpressure: rsp_ready low holds the response indefinitely; no requester is granted until the response is taken.
// Ports: clk/reset (sync, active-high); req_valid/req_ready/req_state/req_block per requester;
//        dp_feedback/dp_state/dp_block/dp_k to the round datapath, dp_result from it;
//        rsp_valid/rsp_ready/rsp_id/rsp_hash toward the consumer.
module sha256_round_sched
    import sha256_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*256-1:0] req_state,
    input  logic [NUM_REQ*512-1:0] req_block,
    output logic                   dp_feedback,
    output logic [255:0]           dp_state,
    output logic [511:0]           dp_block,
    output logic [31:0]            dp_k,
    input  logic [255:0]           dp_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [255:0]           rsp_hash
);

    sched_state_e   state_q,    state_d;
    logic [5:0]     rnd_q,      rnd_d;
    logic [IDW-1:0] last_q,     last_d;
    logic [IDW-1:0] rsp_id_q,   rsp_id_d;
    logic [255:0]   rsp_hash_q, rsp_hash_d;
    logic [255:0]   dp_state_q, dp_state_d;
    logic [511:0]   dp_block_q, dp_block_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic [255:0]       sel_state;
    logic [511:0]       sel_block;
    logic               arb_en;

    // Grants are suppressed during reset so nothing is handed out on a reset edge.
    assign arb_en = (state_q == ST_IDLE) && !reset;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_arb (
        .valid  (req_valid),
        .last   (last_q),
        .enable (arb_en),
        .grant  (grant)
    );

    assign req_ready = grant;

    // One-hot grant to index plus operand selection for the winner.
    always_comb begin
        grant_idx = '0;
        sel_state = '0;
        sel_block = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant[j]) begin
                grant_idx = IDW'(j);
                sel_state = req_state[256*j +: 256];
                sel_block = req_block[512*j +: 512];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rnd_d      = rnd_q;
        last_d     = last_q;
        rsp_id_d   = rsp_id_q;
        rsp_hash_d = rsp_hash_q;
        dp_state_d = dp_state_q;
        dp_block_d = dp_block_q;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    last_d     = grant_idx;
                    rsp_id_d   = grant_idx;
                    rnd_d      = 6'd0;
                    dp_state_d = sel_state;
                    dp_block_d = sel_block;
                    state_d    = ST_ROUND;
                end
            end
            ST_ROUND: begin
                rnd_d = rnd_q + 6'd1;
                if (rnd_q == 6'd63) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                // dp_state still holds the accepted chaining value.
                rsp_hash_d = add_state8(dp_state_q, dp_result);
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rnd_q      <= 6'd0;
            last_q     <= IDW'(NUM_REQ - 1);
            rsp_id_q   <= '0;
            rsp_hash_q <= '0;
            dp_state_q <= '0;
            dp_block_q <= '0;
        end else begin
            state_q    <= state_d;
            rnd_q      <= rnd_d;
            last_q     <= last_d;
            rsp_id_q   <= rsp_id_d;
            rsp_hash_q <= rsp_hash_d;
            dp_state_q <= dp_state_d;
            dp_block_q <= dp_block_d;
        end
    end

    // Round 0 loads fresh operands; every other cycle the datapath recirculates.
    assign dp_feedback = !((state_q == ST_ROUND) && (rnd_q == 6'd0));
    assign dp_k        = (state_q == ST_ROUND) ? K[rnd_q] : 32'h0;
    assign dp_state    = dp_state_q;
    assign dp_block    = dp_block_q;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_id      = rsp_id_q;
    assign rsp_hash    = rsp_hash_q;

endmodule

// File: tb/tb_sha256_round_sched.sv
module tb_sha256_round_sched;

    localparam int N   = 2;
    localparam int IDW = $clog2(N);

    localparam logic [31:0] TB_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] TB_IV     = 256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
    localparam logic [255:0] ABC_HASH  = 256'hf20015ad_b410ff61_96177a9c_b00361a3_5dae2223_414140de_8f01cfea_ba7816bf;
    localparam logic [255:0] NULL_HASH = 256'h7852b855_a495991b_649b934c_27ae41e4_996fb924_9afbf4c8_98fc1c14_e3b0c442;

    logic                 clk;
    logic                 reset;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N*256-1:0]     req_state;
    logic [N*512-1:0]     req_block;
    logic                 dp_feedback;
    logic [255:0]         dp_state;
    logic [511:0]         dp_block;
    logic [31:0]          dp_k;
    logic [255:0]         dp_result;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [255:0]         rsp_hash;

    sha256_round_sched #(.NUM_REQ(N), .IDW(IDW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_state   (req_state),
        .req_block   (req_block),
        .dp_feedback (dp_feedback),
        .dp_state    (dp_state),
        .dp_block    (dp_block),
        .dp_k        (dp_k),
        .dp_result   (dp_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_hash    (rsp_hash)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- SHA-256 primitives ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x); return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22); endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x); return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25); endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x); return ror(x, 7) ^ ror(x, 18) ^ (x >> 3); endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x); return ror(x, 17) ^ ror(x, 19) ^ (x >> 10); endfunction

    // Full compression of one block: the reference for every job.
    function automatic logic [255:0] ref_compress(input logic [255:0] st, input logic [511:0] blk);
        logic [31:0]  w [0:63];
        logic [31:0]  v [0:7];
        logic [31:0]  t1, t2;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
        for (int t = 16; t < 64; t++) w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = st[32*i +: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TB_K[t] + w[t];
            t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        res = '0;
        for (int i = 0; i < 8; i++) res[32*i +: 32] = st[32*i +: 32] + v[i];
        return res;
    endfunction

    // ---------------- one-round datapath environment ----------------
    function automatic logic [255:0] one_round(input logic [255:0] s, input logic [31:0] w, input logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {h, g, f, e, d, c, b, a} = s;
        t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {g, f, e, d + t1, c, b, a, t1 + t2};
    endfunction
    function automatic logic [31:0] msg_next(input logic [511:0] b);
        return ssig1(b[479:448]) + b[319:288] + ssig0(b[63:32]) + b[31:0];
    endfunction

    logic [255:0] env_s_q = '0;
    logic [511:0] env_b_q = '0;
    logic [255:0] env_in_s;
    logic [511:0] env_in_b;
    always_comb begin
        env_in_s = dp_feedback ? env_s_q : dp_state;
        env_in_b = dp_feedback ? env_b_q : dp_block;
    end
    always @(posedge clk) begin
        env_s_q <= one_round(env_in_s, env_in_b[31:0], dp_k);
        env_b_q <= {msg_next(env_in_b), env_in_b[511:32]};
    end
    assign dp_result = env_s_q;

    // ---------------- scoreboard and counters ----------------
    typedef struct packed {
        logic [IDW-1:0] id;
        logic [255:0]   hash;
    } exp_t;

    exp_t         sb [$];
    int           grant_log [$];
    int           acc_cyc_log [$];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    bit           active = 1'b0;
    int           acc_cyc = 0;
    int           model_last = N - 1;
    int           hs_count = 0;
    int           hs_cyc = 0;
    int           last_lat = 0;
    logic [255:0] last_rsp_hash = '0;
    logic [IDW-1:0] last_rsp_id = '0;
    bit           prev_rv = 1'b0;
    bit           prev_hs = 1'b0;
    bit           prev_rst = 1'b1;
    logic [255:0] prev_hash = '0;
    logic [IDW-1:0] prev_id = '0;

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input int last);
        logic [N-1:0] g;
        g = '0;
        for (int i = 1; i <= N; i++) begin
            if (g == '0 && ((v >> ((last + i) % N)) & 1) != 0) begin
                g = '0;
                g[0] = 1'b1;
                g = g << ((last + i) % N);
            end
        end
        return g;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled mid-cycle; decisions apply to the following rising edge.
    always @(negedge clk) begin
        logic [N-1:0] exp_rr;
        logic [N-1:0] acc_vec;
        logic [31:0]  exp_k;
        logic         exp_fb;
        bit           hs;
        int           r;
        int           gid;
        exp_t         e;

        r = cyc - acc_cyc;
        exp_rr = (reset || active) ? '0 : model_grant(req_valid, model_last);
        chk("req_ready", 256'(req_ready), 256'(exp_rr));
        if (active && r >= 0 && r < 64) begin
            exp_k  = TB_K[r];
            exp_fb = (r != 0);
        end else begin
            exp_k  = 32'h0;
            exp_fb = 1'b1;
        end
        chk("dp_k", 256'(dp_k), 256'(exp_k));
        chk("dp_feedback", 256'(dp_feedback), 256'(exp_fb));
        chk("rsp_valid", 256'(rsp_valid), 256'(active && r >= 65));
        if (rsp_valid && !prev_rv) last_lat = r;
        if (rsp_valid && prev_rv && !prev_hs && !prev_rst) begin
            chk("rsp_hash_stable", rsp_hash, prev_hash);
            chk("rsp_id_stable", 256'(rsp_id), 256'(prev_id));
        end

        hs = rsp_valid && rsp_ready && !reset;
        acc_vec = reset ? '0 : (req_valid & req_ready);
        if (hs) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_empty: response id %0d with no job outstanding", rsp_id);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 256'(rsp_id), 256'(e.id));
                chk("rsp_hash", rsp_hash, e.hash);
            end
            last_rsp_hash = rsp_hash;
            last_rsp_id   = rsp_id;
            hs_count++;
            hs_cyc = cyc + 1;
            active = 1'b0;
        end
        if (acc_vec != '0) begin
            gid = 0;
            for (int j = 0; j < N; j++) if (acc_vec[j]) gid = j;
            e.id   = IDW'(gid);
            e.hash = ref_compress(req_state[256*gid +: 256], req_block[512*gid +: 512]);
            sb.push_back(e);
            grant_log.push_back(gid);
            acc_cyc_log.push_back(cyc + 1);
            active     = 1'b1;
            acc_cyc    = cyc + 1;
            model_last = gid;
        end
        if (reset) begin
            active     = 1'b0;
            sb.delete();
            model_last = N - 1;
        end
        prev_rv   = rsp_valid;
        prev_hs   = hs;
        prev_rst  = reset;
        prev_hash = rsp_hash;
        prev_id   = rsp_id;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int id, input logic [255:0] st, input logic [511:0] blk);
        req_state[256*id +: 256] = st;
        req_block[512*id +: 512] = blk;
    endtask

    task automatic set_rand(input int id);
        logic [255:0] st;
        logic [511:0] blk;
        for (int i = 0; i < 8; i++) st[32*i +: 32] = $urandom;
        for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
        set_req(id, st, blk);
    endtask

    task automatic wait_accepts(input int n);
        int target;
        bit ok;
        target = grant_log.size() + n;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (grant_log.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: no grant within 400 cycles");
        end
    endtask

    task automatic wait_hs(input bit rand_ready);
        int target;
        bit ok;
        target = hs_count + 1;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
            tick();
            if (hs_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
        rsp_ready = 1'b1;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_timeout: no response handshake within 600 cycles");
        end
    endtask

    logic [511:0] abc_blk;
    logic [511:0] null_blk;
    int           first;

    initial begin
        abc_blk  = '0;
        abc_blk[31:0]    = 32'h61626380;
        abc_blk[511:480] = 32'h00000018;
        null_blk = '0;
        null_blk[31:0]   = 32'h80000000;

        reset = 1'b1;
        req_valid = '0;
        req_state = '0;
        req_block = '0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_rsp_hash", rsp_hash, 256'h0);
        chk("reset_rsp_id", 256'(rsp_id), 256'h0);
        chk("reset_dp_state", dp_state, 256'h0);
        chk("reset_dp_block", dp_block[255:0] | dp_block[511:256], 256'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        tick();

        // "abc" on requester 0
        set_req(0, TB_IV, abc_blk);
        req_valid[0] = 1'b1;
        wait_accepts(1);
        req_valid = '0;
        wait_hs(1'b0);
        chk("abc_hash", last_rsp_hash, ABC_HASH);
        chk("abc_id", 256'(last_rsp_id), 256'd0);
        chk("abc_latency", 256'(last_lat), 256'd65);

        // empty message on requester 1
        set_req(1, TB_IV, null_blk);
        req_valid[1] = 1'b1;
        wait_accepts(1);
        req_valid = '0;
        wait_hs(1'b0);
        chk("null_hash", last_rsp_hash, NULL_HASH);
        chk("null_id", 256'(last_rsp_id), 256'd1);

        // fairness: both requesters hold valid, fresh job after each grant
        set_rand(0);
        set_rand(1);
        first = grant_log.size();
        req_valid = '1;
        for (int k = 0; k < 4; k++) begin
            wait_accepts(1);
            set_rand(grant_log[grant_log.size() - 1]);
        end
        req_valid = '0;
        wait_hs(1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("fair_order", 256'(grant_log[first + k]), 256'(k % 2));
            if (k > 0) chk("fair_spacing", 256'(acc_cyc_log[first + k] - acc_cyc_log[first + k - 1]), 256'd67);
        end

        // backpressure: hold RESP for 10 cycles with another request pending
        rsp_ready = 1'b0;
        set_rand(0);
        req_valid[0] = 1'b1;
        wait_accepts(1);
        req_valid = '0;
        set_rand(1);
        req_valid[1] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        repeat (10) @(posedge clk);
        #2;
        rsp_ready = 1'b1;
        wait_accepts(1);
        chk("bp_next_accept", 256'(acc_cyc_log[acc_cyc_log.size() - 1] - hs_cyc), 256'd1);
        req_valid = '0;
        wait_hs(1'b0);

        // mid-job reset at round 30, then pointer must be back at requester 0
        set_req(0, TB_IV, abc_blk);
        req_valid[0] = 1'b1;
        wait_accepts(1);
        req_valid = '0;
        repeat (30) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        set_rand(1);
        req_valid = '1;
        wait_accepts(1);
        req_valid = '0;
        chk("post_reset_grant", 256'(grant_log[grant_log.size() - 1]), 256'd0);
        wait_hs(1'b0);
        chk("post_reset_abc", last_rsp_hash, ABC_HASH);
        chk("post_reset_lat", 256'(last_lat), 256'd65);

        // random jobs with random consumer stalls
        for (int j = 0; j < 6; j++) begin
            int id;
            id = int'($urandom_range(0, N - 1));
            set_rand(id);
            req_valid[id] = 1'b1;
            wait_accepts(1);
            req_valid = '0;
            wait_hs(1'b1);
        end

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sha256_round_sched.md
# sha256_round_sched

Round-robin scheduler that shares one iterative SHA-256 round datapath (a single registered digester round with a feedback mux) between `NUM_REQ` requesters. It accepts one compression job (chaining state plus 512-bit block) at a time and sequences the 64 rounds with the correct K constant. It then performs the final word-wise chaining addition and returns the hash with the requester id. It sits between the miner job logic and a one-round hasher instance.

## Interface
- `NUM_REQ`, 2: number of requesters, range 2..8.
- `IDW`, `$clog2(NUM_REQ)`: width of the requester id.
- `clk` in 1: sole clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in `NUM_REQ`: per-requester job valid.
- `req_ready` out `NUM_REQ`: one-hot grant or accept. Combinational from `req_valid`, the state and the pointer.
- `req_state` in `NUM_REQ*256`: chaining state per requester, word a at [31:0] of each slice.
- `req_block` in `NUM_REQ*512`: message block per requester, W0 at [31:0].
- `dp_feedback` out 1: 0 means the datapath takes `dp_state`/`dp_block`; 1 means it takes its own registered outputs.
- `dp_state` out 256: registered copy of the accepted state.
- `dp_block` out 512: registered copy of the accepted block.
- `dp_k` out 32: round constant for the round presented this cycle.
- `dp_result` in 256: digester `tx_state`, registered inside the datapath.
- `rsp_valid` out 1: hash available.
- `rsp_ready` in 1: consumer accepts the hash.
- `rsp_id` out `IDW`: id of the requester that owns the job.
- `rsp_hash` out 256: final hash, word a at [31:0].

## Operation
- States are IDLE, ROUND, FINAL and RESP. Round counter `rnd` is 6 bits.
- **IDLE**
  - Arbitration is round-robin. The search starts at `last+1` mod `NUM_REQ`. The first requester with `req_valid` gets `req_ready`. At most one bit of `req_ready` is high; all are 0 outside IDLE.
  - On the accept edge: latch that requester's `req_state` and `req_block`; set `last` and `rsp_id` to its index; set `rnd=0`; go to ROUND.
- **ROUND**
  - Present round `rnd`: `dp_k = K[rnd]`, and `dp_feedback = (rnd != 0)`.
  - `rnd` increments each cycle. When `rnd==63`, go to FINAL.
- **FINAL** (one cycle)
  - `rsp_hash[32i+:32] <= dp_state[32i+:32] + dp_result[32i+:32]` for i=0..7, modulo 2^32 with no carry between words.
  - Go to RESP.
- **RESP**
  - `rsp_valid=1`. `rsp_hash` and `rsp_id` are held stable.
  - When `rsp_valid && rsp_ready`, go to IDLE.
- In IDLE, FINAL and RESP, `dp_k=0` and `dp_feedback=1`, which is a don't-care for the datapath.
- Reset values:
  - state IDLE, `rnd=0`
  - `last = NUM_REQ-1`, so requester 0 wins first
  - `rsp_valid=0`, `rsp_id=0`, `rsp_hash=0`
  - `dp_state=0`, `dp_block=0`
  - `req_ready=0` while reset is high
- Reset mid-job aborts the job. No response is produced for it and the requester must re-issue.
- A requester that drops `req_valid` before it is granted loses nothing; no job is recorded for it.

## Timing
- Edge E0 is the accept edge. Round r is presented during cycle E_r..E_{r+1} and captured by the datapath at E_{r+1}.
- `dp_result` holds the final round output during cycle E64..E65. FINAL registers the sum at E65.
- `rsp_valid` rises right after E65, so latency is 65 cycles from accept to response.
- The earliest next accept is the edge after the response handshake. Minimum period is 67 cycles per job when `rsp_ready` is held high.
- `rsp_ready` low stalls indefinitely in RESP with no loss of data.

## Structure
- Package `sha256_pkg` holds:
  - `K[0:63]` round constants (K[0]=428a2f98, K[63]=c67178f2)
  - the IV constant 5be0cd19…6a09e667, word a at [31:0]
  - a function `add_state8` for the word-wise 8×32 addition
  - the state enum
- Sub-module `rr_arbiter #(N)`: inputs are the valid vector, `last` and `enable`; output is the one-hot grant. It is purely combinational, and the pointer lives in the scheduler.
- The digester and feedback mux stay outside; the bench instantiates them next to this block.

## Test plan
- **Single "abc" job.** Requester 0, state=IV, block W0=61626380, W15=00000018, others 0. Expect `rsp_valid` exactly 65 cycles after accept, `rsp_id=0`, `rsp_hash[31:0]=ba7816bf` and `[255:224]=f20015ad` (full digest ba7816bf…f20015ad).
- **Empty message.** Block W0=80000000, rest 0, state=IV, on requester 1. Expect hash e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855, `rsp_id=1`.
- **Arbitration fairness.** Both requesters hold valid continuously with distinct blocks. Expect grant order 0,1,0,1; each grant 67 cycles apart with `rsp_ready=1`; never two `req_ready` bits high.
- **Backpressure.** `rsp_ready=0` for 10 cycles in RESP. Expect `rsp_hash`/`rsp_id` stable, `req_ready` all 0, and the next accept one edge after the handshake.
- **Constant sequencing.** Check `dp_feedback=0` with `dp_k=428a2f98` on the cycle after accept, `dp_k=c67178f2` with `dp_feedback=1` 63 cycles later, and `dp_k=0` afterwards.
- **Mid-job reset.** Assert `reset` at round 30 for 1 cycle. Expect no `rsp_valid`, grant pointer back to requester 0, and a subsequent "abc" job correct with 65-cycle latency.
